// File: rtl/accum_buf.sv
// Lane-masked accumulation buffer: 3-stage read-modify-write pipeline over a
// synchronous RAM, with full-entry forwarding and a single-shot drain read port.
module accum_buf #(
  parameter int ADDR_W = 8,
  parameter int BATCH  = 32,
  parameter int DW     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     acc_addr,
  input  logic [BATCH-1:0]      acc_en,
  input  logic                  acc_new,
  input  logic [BATCH*DW-1:0]   acc_data,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_rdy,
  output logic                  rd_vld,
  output logic [BATCH*DW-1:0]   rd_data,
  output logic                  busy
);

  localparam int EW    = BATCH * DW;
  localparam int DEPTH = 1 << ADDR_W;

  logic              op_vld;
  logic              rd_acc;
  logic [ADDR_W-1:0] raddr;

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     ram_q;

  logic              s1_vld, s2_vld, s3_vld, wp_vld, d1_vld;
  logic [ADDR_W-1:0] s1_addr, s2_addr, s3_addr, wp_addr, d1_addr;
  logic [BATCH-1:0]  s1_en, s2_en;
  logic              s1_new, s2_new;
  logic [EW-1:0]     s1_data, s2_data, s2_ram, s3_data, wp_data;
  logic [EW-1:0]     s2_old, s2_result, d1_fwd;

  assign op_vld = |acc_en;
  assign rd_rdy = ~op_vld;
  assign rd_acc = rd_req & rd_rdy;
  assign raddr  = op_vld ? acc_addr : rd_addr;
  assign busy   = s1_vld | s2_vld | s3_vld;

  // Write-first RAM: a read colliding with the S3 commit returns the new entry.
  always_ff @(posedge clk) begin
    if (s3_vld) mem[s3_addr] <= s3_data;
    if (s3_vld && (s3_addr == raddr)) ram_q <= s3_data;
    else                              ram_q <= mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      wp_vld  <= 1'b0;
      d1_vld  <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      s1_vld <= op_vld;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      wp_vld <= s3_vld;
      d1_vld <= rd_acc;
      rd_vld <= d1_vld;
      if (d1_vld) rd_data <= d1_fwd;
    end
  end

  always_ff @(posedge clk) begin
    s1_addr <= acc_addr;
    s1_en   <= acc_en;
    s1_new  <= acc_new;
    s1_data <= acc_data;
    s2_addr <= s1_addr;
    s2_en   <= s1_en;
    s2_new  <= s1_new;
    s2_data <= s1_data;
    s2_ram  <= ram_q;
    s3_addr <= s2_addr;
    s3_data <= s2_result;
    wp_addr <= s3_addr;
    wp_data <= s3_data;
    d1_addr <= rd_addr;
  end

  // S3 is the youngest committed value, so it overrides the write-pending copy.
  always_comb begin
    s2_old = s2_ram;
    if (wp_vld && (wp_addr == s2_addr)) s2_old = wp_data;
    if (s3_vld && (s3_addr == s2_addr)) s2_old = s3_data;
    s2_result = s2_old;
    for (int i = 0; i < BATCH; i++) begin
      if (s2_en[i]) begin
        if (s2_new) s2_result[i*DW +: DW] = s2_data[i*DW +: DW];
        else        s2_result[i*DW +: DW] = s2_old[i*DW +: DW] + s2_data[i*DW +: DW];
      end
    end
  end

  // Drain sees ops still in S2/S3; older ones are already in RAM or bypassed.
  always_comb begin
    d1_fwd = ram_q;
    if (s3_vld && (s3_addr == d1_addr)) d1_fwd = s3_data;
    if (s2_vld && (s2_addr == d1_addr)) d1_fwd = s2_result;
  end

endmodule

// File: tb/tb_accum_buf.sv
// Directed bench for accum_buf: drains push expected entries into a scoreboard
// that an independent monitor pops whenever rd_vld pulses.
module tb_accum_buf;

  localparam int ADDR_W = 8;
  localparam int BATCH  = 32;
  localparam int DW     = 32;
  localparam int EW     = BATCH * DW;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] acc_addr;
  logic [BATCH-1:0]  acc_en;
  logic              acc_new;
  logic [EW-1:0]     acc_data;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              rd_vld;
  logic [EW-1:0]     rd_data;
  logic              busy;

  typedef struct {
    logic [EW-1:0] data;
    int            cyc;
    string         name;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  localparam logic [BATCH-1:0] ALL = '1;

  accum_buf #(.ADDR_W(ADDR_W), .BATCH(BATCH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .acc_addr(acc_addr), .acc_en(acc_en), .acc_new(acc_new),
    .acc_data(acc_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .rd_vld(rd_vld), .rd_data(rd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] fill(input logic [DW-1:0] v);
    logic [EW-1:0] r;
    for (int i = 0; i < BATCH; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  // Monitor: every rd_vld pulse must match the oldest outstanding drain, on time.
  always @(negedge clk) begin
    if (!rst && rd_vld) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rd_vld cycle=%0d lane0=%0h", cyc, rd_data[DW-1:0]);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (rd_data !== e.data || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL %s lane0=%0h lane1=%0h lane31=%0h cycle=%0d required lane0=%0h lane1=%0h lane31=%0h cycle=%0d",
                   e.name, rd_data[DW-1:0], rd_data[2*DW-1:DW], rd_data[EW-1:EW-DW], cyc,
                   e.data[DW-1:0], e.data[2*DW-1:DW], e.data[EW-1:EW-DW], e.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [EW-1:0] actual, input logic [EW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual[63:0], expected[63:0]);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [BATCH-1:0] en,
                               input logic is_new, input logic [EW-1:0] data);
    acc_addr = addr;
    acc_en   = en;
    acc_new  = is_new;
    acc_data = data;
    @(posedge clk);
    #1;
    acc_en  = '0;
    acc_new = 1'b0;
  endtask

  task automatic drain(input logic [ADDR_W-1:0] addr, input logic [EW-1:0] expected, input string name);
    exp_t e;
    rd_req  = 1'b1;
    rd_addr = addr;
    #1;
    checkOutput({name, "_rd_rdy"}, EW'(rd_rdy), EW'(1));
    if (rd_rdy) begin
      e.data = expected;
      e.cyc  = cyc + 2;
      e.name = name;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  initial begin
    logic [EW-1:0] exp3;

    rst      = 1'b1;
    acc_addr = '0;
    acc_en   = '0;
    acc_new  = 1'b0;
    acc_data = '0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    waitCycles(3);
    checkOutput("reset_rd_vld", EW'(rd_vld), EW'(0));
    checkOutput("reset_rd_data", rd_data, '0);
    checkOutput("reset_busy", EW'(busy), EW'(0));
    rst = 1'b0;
    waitCycles(2);
    checkOutput("idle_rd_rdy", EW'(rd_rdy), EW'(1));

    // Overwrite then drain, with busy tracking the op through S1..S3
    applyStimulus(8'd5, ALL, 1'b1, fill(32'd7));
    checkOutput("t1_busy_s1", EW'(busy), EW'(1));
    waitCycles(2);
    checkOutput("t1_busy_s3", EW'(busy), EW'(1));
    waitCycles(1);
    checkOutput("t1_busy_done", EW'(busy), EW'(0));
    drain(8'd5, fill(32'd7), "t1_overwrite");
    waitCycles(3);

    // Back-to-back read-after-write, drained right behind the last add
    applyStimulus(8'd3, ALL, 1'b1, fill(32'd1));
    applyStimulus(8'd3, ALL, 1'b0, fill(32'd2));
    applyStimulus(8'd3, ALL, 1'b0, fill(32'd2));
    applyStimulus(8'd3, ALL, 1'b0, fill(32'd2));
    drain(8'd3, fill(32'd7), "t2_raw");
    waitCycles(4);

    // Gap-of-one hazard with lane masking
    exp3 = fill(32'd0);
    exp3[DW-1:0]    = 32'd10;
    exp3[2*DW-1:DW] = 32'd4;
    applyStimulus(8'd9, ALL, 1'b1, fill(32'd0));
    applyStimulus(8'd9, 32'h1, 1'b0, fill(32'd10));
    waitCycles(1);
    applyStimulus(8'd9, 32'h2, 1'b0, fill(32'd4));
    waitCycles(1);
    drain(8'd9, exp3, "t3_mask");
    waitCycles(4);

    // Two's complement wrap, including the top address
    applyStimulus(8'd16, ALL, 1'b1, fill(32'h7FFF_FFFF));
    applyStimulus(8'd255, ALL, 1'b1, fill(32'hFFFF_FFFF));
    applyStimulus(8'd16, ALL, 1'b0, fill(32'd1));
    applyStimulus(8'd255, ALL, 1'b0, fill(32'd1));
    drain(8'd16, fill(32'h8000_0000), "t4_wrap_pos");
    drain(8'd255, fill(32'h0000_0000), "t4_wrap_zero");
    waitCycles(4);

    // Drain held off by five accumulate cycles to the same address
    for (int k = 0; k < 5; k++) begin
      acc_addr = 8'd20;
      acc_en   = ALL;
      acc_new  = (k == 0);
      acc_data = fill((k == 0) ? 32'd5 : 32'd3);
      rd_req   = 1'b1;
      rd_addr  = 8'd20;
      #1;
      checkOutput($sformatf("t5_reject_%0d", k), EW'(rd_rdy), EW'(0));
      @(posedge clk);
      #1;
    end
    acc_en  = '0;
    acc_new = 1'b0;
    drain(8'd20, fill(32'd17), "t5_arbitration");
    waitCycles(4);

    // Reset in the middle of a burst of adds discards all of them
    applyStimulus(8'd2, ALL, 1'b1, fill(32'd100));
    waitCycles(5);
    applyStimulus(8'd2, ALL, 1'b0, fill(32'd1));
    acc_addr = 8'd2;
    acc_en   = ALL;
    acc_new  = 1'b0;
    acc_data = fill(32'd1);
    rst      = 1'b1;
    #1;
    checkOutput("t6_busy_rst", EW'(busy), EW'(0));
    checkOutput("t6_rd_vld_rst", EW'(rd_vld), EW'(0));
    waitCycles(2);
    acc_en = '0;
    rst    = 1'b0;
    waitCycles(5);
    drain(8'd2, fill(32'd100), "t6_reset_midop");
    waitCycles(4);
    checkOutput("t6_rd_vld_idle", EW'(rd_vld), EW'(0));
    checkOutput("t6_rd_data_hold", rd_data, fill(32'd100));

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout outstanding=%0d required=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
